// File: rtl/uart_defs.sv
// Shared UART definitions for the transmit and receive sides:
// the FSM state encodings, the data width and the bit-period helper.
package uart_defs;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Clock cycles per line bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int f, input int b);
    return (f + b / 2) / b;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO that buffers outgoing bytes for uart_tx.
// Ports: clk, rst (sync, high), push/wdata in, pop/rdata out
// (first-word fall-through), full/empty flags from registered pointers.
// Push while full is accepted only when a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes and sends them as 8N1 frames.
// Ports: clk, rst (sync, high), wr_en/din push, tx line (idle high),
// tx_full, tx_empty (FIFO empty and FSM idle), overflow (sticky).
// Define UART_TX_PARITY_EN to add an even parity bit before stop.
module uart_tx
  import uart_defs::*;
#(
  parameter int SYS_CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE      = 38400,
  parameter int FIFO_ADDR_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  output logic              tx,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              overflow
);

  localparam int CPB = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              ovf_q, ovf_d;
  logic              pop;
  logic              bit_done;
  logic              f_full;
  logic              f_empty;
  logic [DATA_W-1:0] f_rdata;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  uart_tx_fifo #(
    .AW (FIFO_ADDR_BITS),
    .DW (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .wdata (din),
    .pop   (pop),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty)
  );

  assign bit_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    // Down-counter reloads at every bit boundary while a frame runs.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_done ? CNT_MAX : cnt_q - 1'b1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (!f_empty) begin
          state_d = ST_START;
          pop     = 1'b1;
          cnt_d   = CNT_MAX;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        // Chain straight into the next start bit when more is queued.
        if (bit_done) begin
          if (!f_empty) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) shift_d = f_rdata;
  end

  // Line level is registered, so it trails the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_q;
`endif
      ST_STOP:   tx_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign par_d = pop ? ^f_rdata : par_q;
`endif

  assign ovf_d = ovf_q | (wr_en & f_full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign tx_full  = f_full;
  assign tx_empty = f_empty && (state_q == ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 10 clocks per bit.
// A background monitor decodes frames from tx into queues.
module tb_uart_tx;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx;
  logic       tx_full;
  logic       tx_empty;
  logic       overflow;

  uart_tx #(
    .SYS_CLK_FREQ   (1_000_000),
    .BAUD_RATE      (100_000),
    .FIFO_ADDR_BITS (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .din      (din),
    .tx       (tx),
    .tx_full  (tx_full),
    .tx_empty (tx_empty),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rst_cnt = 0;

  logic [7:0] rx_q[$];
  logic       rx_par[$];
  int         rx_t[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) rst_cnt <= rst_cnt + 1;
  end

  // Frame decoder: samples mid-bit on falling clock edges and drops
  // any frame cut by reset or with a bad start/stop bit.
  initial begin : mon
    forever begin
      int         r0;
      int         t0;
      logic [7:0] b;
      logic       p;
      logic       ok;
      logic       s;
      @(negedge tx);
      r0 = rst_cnt;
      @(negedge clk);
      t0 = cyc;
      repeat (4) @(negedge clk);
      ok = (tx === 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      p = 1'b0;
`ifdef UART_TX_PARITY_EN
      repeat (CPB) @(negedge clk);
      p = tx;
`endif
      repeat (CPB) @(negedge clk);
      s = tx;
      if (ok && s === 1'b1 && r0 == rst_cnt) begin
        rx_q.push_back(b);
        rx_par.push_back(p);
        rx_t.push_back(t0);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    tick();
    wr_en = 1'b0;
    din   = 'x;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic rx_clear();
    rx_q.delete();
    rx_par.delete();
    rx_t.delete();
  endtask

  task automatic wait_rx(input int n, input string tag);
    int lim;
    lim = 0;
    while (rx_q.size() < n && lim < 20 * FRAME) begin
      tick();
      lim++;
    end
    chk(tag, rx_q.size(), n);
  endtask

  initial begin
    // reset state
    tick(2);
    rst = 1'b0;
    chk("rst_tx", tx, 1'b1);
    chk("rst_full", tx_full, 1'b0);
    chk("rst_empty", tx_empty, 1'b1);
    chk("rst_ovf", overflow, 1'b0);

    // 1: single byte latency and timing
    rx_clear();
    push(8'hA5);
    chk("t1_lat0", tx, 1'b1);
    chk("t1_busy", tx_empty, 1'b0);
    tick();
    chk("t1_lat1", tx, 1'b1);
    tick();
    chk("t1_start", tx, 1'b0);
    tick(9);
    chk("t1_start_end", tx, 1'b0);
    tick();
    chk("t1_bit0", tx, 1'b1);
    tick(FRAME - 12);
    chk("t1_empty_pre", tx_empty, 1'b0);
    tick();
    chk("t1_empty_post", tx_empty, 1'b1);
    chk("t1_stop", tx, 1'b1);
    wait_rx(1, "t1_nframes");
    chk("t1_byte", rx_q[0], 8'hA5);

    // 2: back-to-back frames, no idle gap
    rx_clear();
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    wait_rx(3, "t2_nframes");
    chk("t2_b0", rx_q[0], 8'h00);
    chk("t2_b1", rx_q[1], 8'hFF);
    chk("t2_b2", rx_q[2], 8'h55);
    chk("t2_gap01", rx_t[1] - rx_t[0], FRAME);
    chk("t2_gap12", rx_t[2] - rx_t[1], FRAME);
    tick(10);
    chk("t2_empty", tx_empty, 1'b1);

    // 3: overflow
    do_reset();
    rx_clear();
    for (int i = 0; i < 9; i++) push(8'h10 + 8'(i));
    chk("t3_full", tx_full, 1'b1);
    chk("t3_ovf_pre", overflow, 1'b0);
    push(8'h19);
    chk("t3_ovf", overflow, 1'b1);
    chk("t3_full2", tx_full, 1'b1);
    wait_rx(9, "t3_nframes");
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("t3_b%0d", i), rx_q[i], 8'h10 + 8'(i));
    end
    chk("t3_ovf_sticky", overflow, 1'b1);
    tick(10);
    chk("t3_empty", tx_empty, 1'b1);
    chk("t3_nodrop_extra", rx_q.size(), 9);
    do_reset();
    chk("t3_ovf_clr", overflow, 1'b0);

    // 4: push into full FIFO on the pop edge
    rx_clear();
    push(8'hC3);
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    chk("t4_full", tx_full, 1'b1);
    chk("t4_ovf_pre", overflow, 1'b0);
    tick(FRAME - 8);
    push(8'hE7);
    chk("t4_ovf", overflow, 1'b0);
    chk("t4_full2", tx_full, 1'b1);
    wait_rx(10, "t4_nframes");
    chk("t4_first", rx_q[0], 8'hC3);
    chk("t4_mid", rx_q[8], 8'h47);
    chk("t4_last", rx_q[9], 8'hE7);

    // 5: reset mid-frame
    tick(20);
    rx_clear();
    push(8'h3C);
    push(8'h11);
    push(8'h22);
    chk("t5_start", tx, 1'b0);
    tick(44);
    chk("t5_bit3", tx, 1'b1);
    do_reset();
    chk("t5_tx", tx, 1'b1);
    chk("t5_empty", tx_empty, 1'b1);
    chk("t5_full", tx_full, 1'b0);
    tick(FRAME + 20);
    chk("t5_idle", tx, 1'b1);
    chk("t5_noframes", rx_q.size(), 0);
    push(8'h81);
    wait_rx(1, "t5_nframes");
    chk("t5_byte", rx_q[0], 8'h81);

`ifdef UART_TX_PARITY_EN
    // 6: even parity
    tick(20);
    rx_clear();
    push(8'h07);
    push(8'h03);
    wait_rx(2, "t6_nframes");
    chk("t6_b0", rx_q[0], 8'h07);
    chk("t6_p0", rx_par[0], 1'b1);
    chk("t6_b1", rx_q[1], 8'h03);
    chk("t6_p1", rx_par[1], 1'b0);
    chk("t6_len", rx_t[1] - rx_t[0], 110);
`endif

    tick(20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
